// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: h/v counters, a registered decode stage that
// drives the look-ahead request channel, and a LEAD-deep delay line to the RGB outputs.
module video_timing_gen #(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 21,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LEAD     = 2
) (
    input  logic          rgb_clk,
    input  logic          rgb_rst_n,
    input  logic          en,
    output logic          rgb_req,
    output logic [CW-1:0] req_x,
    output logic [CW-1:0] req_y,
    output logic          frame_start,
    output logic          line_start,
    output logic          rgb_hs,
    output logic          rgb_vs,
    output logic          rgb_de,
    output logic [CW-1:0] rgb_x,
    output logic [CW-1:0] rgb_y
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;
    localparam longint CNT_CAP = longint'(1) << CW;

    localparam logic [CW-1:0] H_LAST_C  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST_C  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_BLANK_C = CW'(H_BLANK);
    localparam logic [CW-1:0] V_BLANK_C = CW'(V_BLANK);
    localparam logic [CW-1:0] HS_ON_C   = CW'(H_FP);
    localparam logic [CW-1:0] HS_OFF_C  = CW'(H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_ON_C   = CW'(V_FP);
    localparam logic [CW-1:0] VS_OFF_C  = CW'(V_FP + V_SYNC);

    // Delay-line word: {hs_act, vs_act, de, x, y}
    localparam int PW = 3 + 2 * CW;

    if ((longint'(H_TOTAL) > CNT_CAP) || (longint'(V_TOTAL) > CNT_CAP)) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end
    if ((LEAD < 0) || (LEAD > 15)) begin : g_bad_lead
        $error("video_timing_gen: LEAD must be 0..15");
    end
    if ((H_SYNC == 0) || (V_SYNC == 0) || (H_ACTIVE == 0) || (V_ACTIVE == 0)) begin : g_bad_zero
        $error("video_timing_gen: sync and active widths must be non-zero");
    end

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic          w_h_wrap;
    logic          w_v_wrap;

    assign w_h_wrap = (r_h_cnt == H_LAST_C);
    assign w_v_wrap = (r_v_cnt == V_LAST_C);

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + CW'(1);
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CW'(1);
            end
        end
    end

    logic w_hs_act;
    logic w_vs_act;
    logic w_de;

    assign w_hs_act = (r_h_cnt >= HS_ON_C) && (r_h_cnt < HS_OFF_C);
    assign w_vs_act = (r_v_cnt >= VS_ON_C) && (r_v_cnt < VS_OFF_C);
    assign w_de     = (r_h_cnt >= H_BLANK_C) && (r_v_cnt >= V_BLANK_C);

    // Request stage: coordinates are zeroed outside the active area so they are never stale.
    logic          r_req;
    logic [CW-1:0] r_req_x;
    logic [CW-1:0] r_req_y;
    logic          r_frame_start;
    logic          r_line_start;
    logic          r_hs_act;
    logic          r_vs_act;

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            r_req         <= 1'b0;
            r_req_x       <= '0;
            r_req_y       <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_hs_act      <= 1'b0;
            r_vs_act      <= 1'b0;
        end else if (!en) begin
            r_req         <= 1'b0;
            r_req_x       <= '0;
            r_req_y       <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_hs_act      <= 1'b0;
            r_vs_act      <= 1'b0;
        end else begin
            r_req         <= w_de;
            r_req_x       <= w_de ? (r_h_cnt - H_BLANK_C) : '0;
            r_req_y       <= w_de ? (r_v_cnt - V_BLANK_C) : '0;
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            r_line_start  <= (r_h_cnt == '0);
            r_hs_act      <= w_hs_act;
            r_vs_act      <= w_vs_act;
        end
    end

    assign rgb_req     = r_req;
    assign req_x       = r_req_x;
    assign req_y       = r_req_y;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

    logic [PW-1:0] w_s0;
    logic [PW-1:0] w_out;

    assign w_s0 = {r_hs_act, r_vs_act, r_req, r_req_x, r_req_y};

    // The delay line keeps shifting while en is low, so inactive words drain through it.
    if (LEAD == 0) begin : g_no_delay
        assign w_out = w_s0;
    end else begin : g_delay
        for (genvar gi = 0; gi < LEAD; gi++) begin : g_tap
            logic [PW-1:0] r_stage;
            logic [PW-1:0] w_src;
            if (gi == 0) begin : g_first
                assign w_src = w_s0;
            end else begin : g_next
                assign w_src = g_tap[gi-1].r_stage;
            end
            always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
                if (!rgb_rst_n) begin
                    r_stage <= '0;
                end else begin
                    r_stage <= w_src;
                end
            end
        end
        assign w_out = g_tap[LEAD-1].r_stage;
    end

    assign rgb_hs = w_out[PW-1] ? HS_POL : ~HS_POL;
    assign rgb_vs = w_out[PW-2] ? VS_POL : ~VS_POL;
    assign rgb_de = w_out[PW-3];
    assign rgb_x  = w_out[2*CW-1:CW];
    assign rgb_y  = w_out[CW-1:0];

endmodule
